bdf_prog_sequencer: RTL and testbench

//  Program-memory sequencer feeding the buffer array of the matrix-vector multiplier datapath.
//  - Holds up to CODE_LENGTH control words of CODE_WIDTH bits, loaded over a write port.
//  - On start, steps through the words once.
//  - Decodes each word into per-buffer push/pop strobes.
//  - Stalls while any addressed buffer cannot accept the operation.

---
 rtl/bdf_prog_sequencer.sv | 126 ++++++++++++
 tb/tb_bdf_prog_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bdf_prog_sequencer.sv
// Program-memory sequencer: steps once through loaded control words and issues per-buffer
// push/pop strobes, stalling whole words on buffer status. Optional macro: STALL_CNT_EN.
module bdf_prog_sequencer #(
  parameter int unsigned NUM_BUFFERS = 12,
  parameter int unsigned CODE_LENGTH = 64,
  parameter int unsigned CODE_WIDTH  = NUM_BUFFERS * 2,
  parameter int unsigned AW          = $clog2(CODE_LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prog_we,
  input  logic [AW-1:0]          prog_addr,
  input  logic [CODE_WIDTH-1:0]  prog_data,
  input  logic [AW:0]            prog_len,
  input  logic                   start,
  input  logic [NUM_BUFFERS-1:0] buf_full,
  input  logic [NUM_BUFFERS-1:0] buf_empty,
  output logic [NUM_BUFFERS-1:0] buf_push,
  output logic [NUM_BUFFERS-1:0] buf_pop,
  output logic [AW-1:0]          pc,
  output logic                   busy,
  output logic                   done
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  localparam logic [AW:0] CodeLen = (AW+1)'(CODE_LENGTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           pc_q, pc_d;
  logic [AW:0]             len_q, len_d;
  logic [CODE_WIDTH-1:0]   mem [CODE_LENGTH];
  logic [CODE_WIDTH-1:0]   word;
  logic [NUM_BUFFERS-1:0]  push_dec, pop_dec;
  logic                    stall;
  logic                    last;

  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // A write to the word being executed is forwarded so it takes effect this cycle.
  assign word = (prog_we && (prog_addr == pc_q)) ? prog_data : mem[pc_q];

  always_comb begin
    push_dec = '0;
    pop_dec  = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      push_dec[i] = word[2*i];
      pop_dec[i]  = word[2*i+1];
    end
  end

  // Push into a full buffer is fine when the same buffer pops in the same cycle.
  assign stall = |((push_dec & buf_full & ~pop_dec) | (pop_dec & buf_empty));
  assign last  = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    buf_push = '0;
    buf_pop  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = (prog_len > CodeLen) ? CodeLen : prog_len;
          pc_d    = '0;
          state_d = (prog_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (!stall) begin
          buf_push = push_dec;
          buf_pop  = pop_dec;
          if (last) state_d = StDone;
          else      pc_d    = pc_q + AW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        pc_d    = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
    end
  end

  assign pc = pc_q;

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StRun) && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bdf_prog_sequencer.sv
// Scoreboard bench for bdf_prog_sequencer: a timeline model queues expected strobe/done
// events per word; a negedge monitor pops and compares whenever the DUT shows an output.
module tb_bdf_prog_sequencer;
  localparam int NB = 12;
  localparam int CL = 64;
  localparam int AW = 6;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [CW-1:0] prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic [NB-1:0] buf_full = '0;
  logic [NB-1:0] buf_empty = '0;
  logic [NB-1:0] buf_push, buf_pop;
  logic [AW-1:0] pc;
  logic          busy, done;
`ifdef STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  bdf_prog_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .buf_full  (buf_full),
    .buf_empty (buf_empty),
    .buf_push  (buf_push),
    .buf_pop   (buf_pop),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    bit            is_done;
    int            pc;
    logic [NB-1:0] push;
    logic [NB-1:0] pop;
  } ev_t;

  ev_t           exp_q[$];
  logic [CW-1:0] prog [CL];
  int            total = 0;
  int            bad = 0;
  bit            mon_en = 1'b0;
  int            stall_exp = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [NB-1:0] field_push(input logic [CW-1:0] w);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = (w[2*i+:2] == 2'b01) || (w[2*i+:2] == 2'b11);
    return r;
  endfunction

  function automatic logic [NB-1:0] field_pop(input logic [CW-1:0] w);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = (w[2*i+:2] == 2'b10) || (w[2*i+:2] == 2'b11);
    return r;
  endfunction

  function automatic logic [CW-1:0] rand_word();
    logic [CW-1:0] w;
    w = CW'($urandom);
    for (int i = 0; i < NB; i++) if ($urandom_range(0, 2) == 0) w[2*i+:2] = 2'b00;
    if ($urandom_range(0, 7) == 0) w = '0;
    return w;
  endfunction

  // Monitor: any visible strobe or done must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && ((buf_push != '0) || (buf_pop != '0) || done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'({done, buf_pop, buf_push}), 32'd0);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("done_kind", 32'(done), 32'(ev.is_done));
        if (!ev.is_done) begin
          check("push", 32'(buf_push), 32'(ev.push));
          check("pop", 32'(buf_pop), 32'(ev.pop));
          check("pc", 32'(pc), 32'(ev.pc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    prog_we   = 1'b0;
    start     = 1'b0;
    buf_full  = '0;
    buf_empty = '0;
  endtask

  // Status under which word w issues: no pop to an empty buffer, no lone push to a full one.
  task automatic clean_status(input logic [CW-1:0] w, input bit noise);
    for (int i = 0; i < NB; i++) begin
      case (w[2*i+:2])
        2'b00: begin buf_full[i] = noise & $urandom_range(0, 1); buf_empty[i] = noise & $urandom_range(0, 1); end
        2'b01: begin buf_full[i] = 1'b0; buf_empty[i] = noise & $urandom_range(0, 1); end
        2'b10: begin buf_full[i] = noise & $urandom_range(0, 1); buf_empty[i] = 1'b0; end
        default: begin buf_full[i] = noise ? 1'($urandom_range(0, 1)) : 1'b1; buf_empty[i] = 1'b0; end
      endcase
    end
  endtask

  task automatic stall_status(input logic [CW-1:0] w, input bit noise);
    int cands[$];
    int idx;
    clean_status(w, noise);
    for (int i = 0; i < NB; i++) if (w[2*i+:2] != 2'b00) cands.push_back(i);
    idx = cands[$urandom_range(0, cands.size() - 1)];
    if (w[2*idx+1]) buf_empty[idx] = 1'b1;
    else            buf_full[idx]  = 1'b1;
  endtask

  task automatic load_words(input logic [CW-1:0] ws[$]);
    for (int a = 0; a < ws.size(); a++) begin
      tick();
      prog_we   = 1'b1;
      prog_addr = AW'(a);
      prog_data = ws[a];
      prog[a]   = ws[a];
    end
  endtask

  // One pass on the model's timeline: per word, some stall cycles then the issue cycle.
  task automatic run_pass(input int len_in, input int fixed_stall, input bit noise,
                          input bit bypass, input int reset_at);
    int len;
    int nst;
    logic [CW-1:0] w;
    tick();
    start     = 1'b1;
    prog_len  = (AW+1)'(len_in);
    len       = (len_in > CL) ? CL : len_in;
    stall_exp = 0;
    for (int k = 0; k < len; k++) begin
      w   = prog[k];
      nst = 0;
      if (w != '0) nst = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, 3));
      for (int s = 0; s < nst; s++) begin
        tick();
        stall_status(w, noise);
        stall_exp++;
        if (noise && $urandom_range(0, 3) == 0) begin
          start    = 1'b1;
          prog_len = (AW+1)'($urandom);
        end
      end
      tick();
      if (bypass && $urandom_range(0, 5) == 0) begin
        w         = rand_word();
        prog_we   = 1'b1;
        prog_addr = AW'(k);
        prog_data = w;
        prog[k]   = w;
      end
      clean_status(w, noise);
      if (k == 0) check("busy_run", 32'(busy), 32'd1);
      if (w != '0) exp_q.push_back('{is_done: 1'b0, pc: k, push: field_push(w), pop: field_pop(w)});
      if (k == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("busy_after_reset", 32'(busy), 32'd0);
        check("done_after_reset", 32'(done), 32'd0);
        check("pc_after_reset", 32'(pc), 32'd0);
`ifdef STALL_CNT_EN
        check("stall_cnt_after_reset", 32'(stall_cycles), 32'd0);
`endif
        return;
      end
    end
    tick();
    exp_q.push_back('{is_done: 1'b1, pc: 0, push: '0, pop: '0});
    if (noise) begin
      start    = 1'b1;
      prog_len = (AW+1)'($urandom);
    end
    tick();
    check("pc_idle", 32'(pc), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
`ifdef STALL_CNT_EN
    check("stall_cycles", 32'(stall_cycles), 32'(stall_exp));
`endif
  endtask

  initial begin
    logic [CW-1:0] ws[$];
    for (int a = 0; a < CL; a++) prog[a] = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_strobes", 32'({buf_push, buf_pop}), 32'd0);
`ifdef STALL_CNT_EN
    check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
`endif
    mon_en = 1'b1;

    ws = '{24'h000001, 24'h000002, 24'h000004, 24'h000008};
    ws[1] = 24'h000004;
    ws[2] = 24'h000010;
    ws[3] = 24'h000040;
    load_words(ws);
    run_pass(4, 0, 1'b0, 1'b0, -1);

    ws = '{24'h000002};
    load_words(ws);
    run_pass(1, 3, 1'b0, 1'b0, -1);

    ws = '{24'h000003};
    load_words(ws);
    run_pass(1, 0, 1'b0, 1'b0, -1);

    run_pass(0, 0, 1'b0, 1'b0, -1);

    ws.delete();
    for (int a = 0; a < CL; a++) ws.push_back(24'hFFFFFF);
    load_words(ws);
    run_pass(CL, 0, 1'b0, 1'b0, -1);

    ws.delete();
    for (int a = 0; a < CL; a++) ws.push_back(rand_word() | 24'h000001);
    load_words(ws);
    run_pass(40, 0, 1'b0, 1'b0, 10);
    run_pass(40, 0, 1'b0, 1'b0, -1);

    for (int p = 0; p < 12; p++) begin
      if (p % 3 == 0) begin
        ws.delete();
        for (int a = 0; a < CL; a++) ws.push_back(rand_word());
        load_words(ws);
      end
      run_pass(int'($urandom_range(0, 90)), -1, 1'b1, 1'b1, -1);
    end

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
